lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/rv_pkg.sv | 66 ++++++
 rtl/lsu_if.sv | 39 +++
 rtl/lsu_load_ext.sv | 24 ++
 rtl/lsu.sv | 153 +++++++++++++++
 tb/tb_lsu.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I load/store types for the LSU.
// Holds the access-size, status and FSM-state enums, the funct3 encodings,
// and small decode helpers (size from funct3, legality, alignment).
package rv_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HWORD = 2'd1,
        WORD  = 2'd2
    } mem_op_sz_e;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        MISALIGNED = 2'd1,
        TIMEOUT    = 2'd2
    } lsu_err_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_WAIT  = 2'd1,
        STORE_WAIT = 2'd2,
        RESP       = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size comes from the low two funct3 bits; 11 is only seen on illegal ops.
    function automatic mem_op_sz_e size_of(input logic [2:0] f3);
        mem_op_sz_e sz;
        case (f3[1:0])
            2'b00:   sz = BYTE;
            2'b01:   sz = HWORD;
            default: sz = WORD;
        endcase
        return sz;
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        return ok;
    endfunction

    function automatic logic addr_misaligned(input mem_op_sz_e sz, input logic [1:0] a);
        logic bad;
        case (sz)
            HWORD:   bad = a[0];
            WORD:    bad = (a != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// LSU bus bundle: pipeline request/response handshake plus memory port.
// Signal names carry their direction as seen from the LSU (i_ = into LSU).
// slave  : LSU side.  master : pipeline/memory environment side.
interface lsu_if;
    import rv_pkg::*;

    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [2:0]  i_req_funct3;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic [31:0] o_resp_rdata;
    lsu_err_e    o_resp_err;
    logic        o_mem_we;
    logic        o_mem_re;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    mem_op_sz_e  o_mem_size;
    logic [31:0] i_mem_rdata;
    logic        i_mem_data_ready;
    logic        i_mem_write_ready;

    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_funct3,
        input  i_resp_ready, i_mem_rdata, i_mem_data_ready, i_mem_write_ready,
        output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
        output o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata, o_mem_size
    );

    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_funct3,
        output i_resp_ready, i_mem_rdata, i_mem_data_ready, i_mem_write_ready,
        input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
        input  o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata, o_mem_size
    );
endinterface

// File: rtl/lsu_load_ext.sv
// Combinational load-data extension.
// Ports: i_data (right-aligned memory data), i_funct3 (load kind),
//        o_data (sign/zero-extended result; LW and anything else pass through).
module lsu_load_ext
    import rv_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    // Extend byte/halfword loads to 32 bits.
    always_comb begin
        o_data = i_data;
        case (i_funct3)
            F3_LB:   o_data = {{24{i_data[7]}}, i_data[7:0]};
            F3_LH:   o_data = {{16{i_data[15]}}, i_data[15:0]};
            F3_LBU:  o_data = {24'd0, i_data[7:0]};
            F3_LHU:  o_data = {16'd0, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one pipeline request at a time, performs a single
// memory access with a bounded wait, and returns an extended load value plus a
// status code (NONE / MISALIGNED / TIMEOUT).
// Ports: i_clk, i_rst (async, active-high), bus (lsu_if.slave: request,
//        response and memory signals). TimeoutCycles bounds the wait states.
module lsu
    import rv_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic  i_clk,
    input  logic  i_rst,
    lsu_if.slave  bus
);

    localparam int unsigned    CntW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    lsu_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    mem_op_sz_e      size_q, size_d;
    logic [31:0]     rdata_q, rdata_d;
    lsu_err_e        err_q, err_d;

    mem_op_sz_e      req_size_s;
    logic            req_bad_s;
    logic [31:0]     ext_data_s;

    assign req_size_s = size_of(bus.i_req_funct3);
    // Illegal funct3 encodings are reported with the same MISALIGNED code.
    assign req_bad_s  = !funct3_legal(bus.i_req_we, bus.i_req_funct3) ||
                        addr_misaligned(req_size_s, bus.i_req_addr[1:0]);

    lsu_load_ext u_load_ext (
        .i_data   (bus.i_mem_rdata),
        .i_funct3 (funct3_q),
        .o_data   (ext_data_s)
    );

    // Next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        size_d   = size_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.i_req_valid) begin
                    addr_d   = bus.i_req_addr;
                    wdata_d  = bus.i_req_wdata;
                    we_d     = bus.i_req_we;
                    funct3_d = bus.i_req_funct3;
                    size_d   = req_size_s;
                    cnt_d    = '0;
                    rdata_d  = 32'd0;
                    err_d    = NONE;
                    if (req_bad_s) begin
                        state_d = RESP;
                        err_d   = MISALIGNED;
                    end else if (bus.i_req_we) begin
                        state_d = STORE_WAIT;
                    end else begin
                        state_d = LOAD_WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_WAIT: begin
                // The ready strobe takes priority over the timeout.
                if (bus.i_mem_data_ready) begin
                    rdata_d = ext_data_s;
                    err_d   = NONE;
                    state_d = RESP;
                end else if (cnt_q == CntLast) begin
                    rdata_d = 32'd0;
                    err_d   = TIMEOUT;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            STORE_WAIT: begin
                if (bus.i_mem_write_ready) begin
                    rdata_d = 32'd0;
                    err_d   = NONE;
                    state_d = RESP;
                end else if (cnt_q == CntLast) begin
                    rdata_d = 32'd0;
                    err_d   = TIMEOUT;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RESP: begin
                // Return to IDLE only; a new request waits for the next cycle.
                if (bus.i_resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            size_q   <= BYTE;
            rdata_q  <= 32'd0;
            err_q    <= NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            size_q   <= size_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Ready is also masked by reset so it reads 0 while reset is held.
    assign bus.o_req_ready  = (state_q == IDLE) && !i_rst;
    assign bus.o_resp_valid = (state_q == RESP);
    assign bus.o_resp_rdata = rdata_q;
    assign bus.o_resp_err   = err_q;
    assign bus.o_mem_re     = (state_q == LOAD_WAIT) && !we_q;
    assign bus.o_mem_we     = (state_q == STORE_WAIT) && we_q;
    assign bus.o_mem_addr   = addr_q;
    assign bus.o_mem_wdata  = wdata_q;
    assign bus.o_mem_size   = size_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
    import rv_pkg::*;

    localparam int MemBytes = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lsu_if bus();

    lsu #(.TimeoutCycles(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 0;
    int lat_cnt;
    logic mem_init = 1'b1;
    logic [7:0] mem     [0:MemBytes-1];
    logic [7:0] ref_mem [0:MemBytes-1];

    // ---------------- memory responder ----------------
    function automatic int m_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        else if (f3[1:0] == 2'b01) return 2;
        else return 4;
    endfunction

    function automatic int sz_bytes(input mem_op_sz_e s);
        if (s == BYTE) return 1;
        else if (s == HWORD) return 2;
        else return 4;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) lat_cnt <= 0;
        else if (bus.o_mem_re || bus.o_mem_we) lat_cnt <= lat_cnt + 1;
        else lat_cnt <= 0;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MemBytes; i++) mem[i] <= 8'h00;
        end else if (bus.o_mem_we && bus.i_mem_write_ready && bus.o_mem_addr < MemBytes) begin
            for (int k = 0; k < sz_bytes(bus.o_mem_size); k++)
                mem[(int'(bus.o_mem_addr[7:0]) + k) % MemBytes] <= bus.o_mem_wdata[8*k +: 8];
        end
    end

    always_comb begin
        bus.i_mem_data_ready  = bus.o_mem_re && (lat_cnt >= mem_lat);
        bus.i_mem_write_ready = bus.o_mem_we && (lat_cnt >= mem_lat);
        bus.i_mem_rdata       = 32'd0;
        if (bus.o_mem_addr < MemBytes) begin
            for (int k = 0; k < 4; k++)
                if (k < sz_bytes(bus.o_mem_size))
                    bus.i_mem_rdata[8*k +: 8] = mem[(int'(bus.o_mem_addr[7:0]) + k) % MemBytes];
        end
    end

    // ---------------- reference model ----------------
    function automatic bit m_bad(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return !legal || ((addr % m_bytes(f3)) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        longint raw;
        raw = 0;
        if (addr < MemBytes)
            for (int k = 0; k < m_bytes(f3); k++)
                raw += longint'(ref_mem[int'(addr) + k]) << (8 * k);
        if (f3 == 3'd0 && raw >= 128) raw -= 256;
        if (f3 == 3'd1 && raw >= 32768) raw -= 65536;
        return raw[31:0];
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        if (addr < MemBytes)
            for (int k = 0; k < m_bytes(f3); k++)
                ref_mem[int'(addr) + k] = 8'((wd >> (8 * k)) & 32'hFF);
    endtask

    // ---------------- transaction driver (no checking) ----------------
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output lsu_err_e er,
                         output int lat, output int re_cnt, output int we_cnt,
                         output mem_op_sz_e sz, output logic [31:0] maddr,
                         output logic [31:0] mwd, output bit steady);
        int guard;
        guard = 0;
        while (!bus.o_req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.i_req_valid  = 1'b1;
        bus.i_req_we     = we;
        bus.i_req_funct3 = f3;
        bus.i_req_addr   = addr;
        bus.i_req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        lat = 1; re_cnt = 0; we_cnt = 0; steady = 1'b1;
        sz = BYTE; maddr = 32'd0; mwd = 32'd0;
        while (!bus.o_resp_valid && lat < 200) begin
            if (bus.o_mem_re || bus.o_mem_we) begin
                if (re_cnt + we_cnt == 0) begin
                    sz = bus.o_mem_size; maddr = bus.o_mem_addr; mwd = bus.o_mem_wdata;
                end else if (sz !== bus.o_mem_size || maddr !== bus.o_mem_addr ||
                             mwd !== bus.o_mem_wdata) begin
                    steady = 1'b0;
                end
            end
            re_cnt += int'(bus.o_mem_re);
            we_cnt += int'(bus.o_mem_we);
            @(negedge clk);
            lat++;
        end
        re_cnt += int'(bus.o_mem_re);
        we_cnt += int'(bus.o_mem_we);
        rd = bus.o_resp_rdata;
        er = bus.o_resp_err;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++; if (bus.o_req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", bus.o_req_ready); end
        checks++; if (bus.o_resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", bus.o_resp_valid); end
        checks++; if (bus.o_resp_rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", bus.o_resp_rdata); end
        checks++; if (bus.o_resp_err !== NONE) begin failures++; $display("FAIL rst_err got=%0d exp=0", bus.o_resp_err); end
        checks++; if ({bus.o_mem_we, bus.o_mem_re} !== 2'b00) begin failures++; $display("FAIL rst_mem_en got=%b exp=00", {bus.o_mem_we, bus.o_mem_re}); end
        checks++; if ({bus.o_mem_addr, bus.o_mem_wdata} !== 64'd0 || bus.o_mem_size !== BYTE) begin failures++; $display("FAIL rst_mem_bus got=%h/%h/%0d exp=0", bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_size); end
        @(negedge clk);
        rst = 1'b0;
        mem_init = 1'b0;
        #1;
        checks++; if (bus.o_req_ready !== 1'b1) begin failures++; $display("FAIL rel_req_ready got=%b exp=1", bus.o_req_ready); end
        @(negedge clk);
    endtask

    task automatic test_word_and_bytes();
        logic [31:0] rd, ma, mw; lsu_err_e er; int lat, rc, wc; mem_op_sz_e sz; bit st;
        mem_lat = 0;
        issue(1'b1, 3'b010, 32'h4, 32'hDEADBEEF, rd, er, lat, rc, wc, sz, ma, mw, st);
        ref_store(3'b010, 32'h4, 32'hDEADBEEF);
        checks++; if (wc !== 1 || sz !== WORD) begin failures++; $display("FAIL sw_we_pulse got=%0d/%0d exp=1/2", wc, sz); end
        checks++; if (er !== NONE || rd !== 32'd0 || lat !== 2) begin failures++; $display("FAIL sw_resp got=%0d/%h/%0d exp=0/0/2", er, rd, lat); end
        issue(1'b0, 3'b010, 32'h4, 32'h0, rd, er, lat, rc, wc, sz, ma, mw, st);
        checks++; if (rd !== 32'hDEADBEEF || er !== NONE || lat !== 2) begin failures++; $display("FAIL lw_data got=%h/%0d/%0d exp=deadbeef/0/2", rd, er, lat); end
        issue(1'b1, 3'b000, 32'h2, 32'h80, rd, er, lat, rc, wc, sz, ma, mw, st);
        ref_store(3'b000, 32'h2, 32'h80);
        checks++; if (sz !== BYTE || wc !== 1) begin failures++; $display("FAIL sb_size got=%0d/%0d exp=0/1", sz, wc); end
        issue(1'b0, 3'b000, 32'h2, 32'h0, rd, er, lat, rc, wc, sz, ma, mw, st);
        checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_sext got=%h exp=ffffff80", rd); end
        issue(1'b0, 3'b100, 32'h2, 32'h0, rd, er, lat, rc, wc, sz, ma, mw, st);
        checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL lbu_zext got=%h exp=00000080", rd); end
        issue(1'b1, 3'b001, 32'h8, 32'h8001, rd, er, lat, rc, wc, sz, ma, mw, st);
        ref_store(3'b001, 32'h8, 32'h8001);
        issue(1'b0, 3'b001, 32'h8, 32'h0, rd, er, lat, rc, wc, sz, ma, mw, st);
        checks++; if (rd !== 32'hFFFF8001 || sz !== HWORD) begin failures++; $display("FAIL lh_sext got=%h/%0d exp=ffff8001/1", rd, sz); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, ma, mw; lsu_err_e er; int lat, rc, wc; mem_op_sz_e sz; bit st;
        issue(1'b0, 3'b010, 32'h6, 32'h0, rd, er, lat, rc, wc, sz, ma, mw, st);
        checks++; if (er !== MISALIGNED || rd !== 32'd0 || lat !== 1 || rc + wc !== 0) begin failures++; $display("FAIL lw_mis got=%0d/%h/%0d/%0d exp=1/0/1/0", er, rd, lat, rc + wc); end
        issue(1'b0, 3'b001, 32'h3, 32'h0, rd, er, lat, rc, wc, sz, ma, mw, st);
        checks++; if (er !== MISALIGNED || rd !== 32'd0 || lat !== 1 || rc + wc !== 0) begin failures++; $display("FAIL lh_mis got=%0d/%h/%0d/%0d exp=1/0/1/0", er, rd, lat, rc + wc); end
        issue(1'b1, 3'b100, 32'h0, 32'h1, rd, er, lat, rc, wc, sz, ma, mw, st);
        checks++; if (er !== MISALIGNED || lat !== 1 || rc + wc !== 0) begin failures++; $display("FAIL st_bad_f3 got=%0d/%0d/%0d exp=1/1/0", er, lat, rc + wc); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd, ma, mw; lsu_err_e er; int lat, rc, wc; mem_op_sz_e sz; bit st;
        mem_lat = 30;
        issue(1'b0, 3'b010, 32'h4, 32'h0, rd, er, lat, rc, wc, sz, ma, mw, st);
        checks++; if (er !== TIMEOUT || rd !== 32'd0 || lat !== 17 || rc !== 16) begin failures++; $display("FAIL ld_timeout got=%0d/%h/%0d/%0d exp=2/0/17/16", er, rd, lat, rc); end
        mem_lat = 15;
        issue(1'b0, 3'b010, 32'h4, 32'h0, rd, er, lat, rc, wc, sz, ma, mw, st);
        checks++; if (er !== NONE || rd !== 32'hDEADBEEF || lat !== 17 || !st) begin failures++; $display("FAIL ld_ready_last got=%0d/%h/%0d/%0d exp=0/deadbeef/17/1", er, rd, lat, st); end
        mem_lat = 30;
        issue(1'b1, 3'b010, 32'h10, 32'h55AA55AA, rd, er, lat, rc, wc, sz, ma, mw, st);
        checks++; if (er !== TIMEOUT || lat !== 17 || wc !== 16) begin failures++; $display("FAIL st_timeout got=%0d/%0d/%0d exp=2/17/16", er, lat, wc); end
        mem_lat = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd0; lsu_err_e er0; int bad, guard;
        mem_lat = 0;
        bus.i_resp_ready = 1'b0;
        bus.i_req_valid = 1'b1; bus.i_req_we = 1'b0; bus.i_req_funct3 = 3'b010;
        bus.i_req_addr = 32'h4; bus.i_req_wdata = 32'd0;
        @(posedge clk); @(negedge clk);
        bus.i_req_addr = 32'h8;
        @(posedge clk); @(negedge clk);
        rd0 = bus.o_resp_rdata; er0 = bus.o_resp_err;
        checks++; if (rd0 !== 32'hDEADBEEF || er0 !== NONE) begin failures++; $display("FAIL bp_first got=%h/%0d exp=deadbeef/0", rd0, er0); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.o_resp_valid !== 1'b1 || bus.o_resp_rdata !== rd0 || bus.o_resp_err !== er0 ||
                bus.o_req_ready !== 1'b0 || bus.o_mem_re !== 1'b0) bad++;
            @(posedge clk); @(negedge clk);
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad); end
        bus.i_resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (bus.o_resp_valid !== 1'b0 || bus.o_req_ready !== 1'b1 || bus.o_mem_re !== 1'b0) begin failures++; $display("FAIL bp_no_bypass got=%b%b%b exp=010", bus.o_resp_valid, bus.o_req_ready, bus.o_mem_re); end
        @(posedge clk); @(negedge clk);
        bus.i_req_valid = 1'b0;
        checks++; if (bus.o_mem_re !== 1'b1 || bus.o_mem_addr !== 32'h8) begin failures++; $display("FAIL bp_next_accept got=%b/%h exp=1/8", bus.o_mem_re, bus.o_mem_addr); end
        guard = 0;
        while (!bus.o_resp_valid && guard < 50) begin @(negedge clk); guard++; end
        checks++; if (bus.o_resp_rdata !== ref_load(3'b010, 32'h8)) begin failures++; $display("FAIL bp_second got=%h exp=%h", bus.o_resp_rdata, ref_load(3'b010, 32'h8)); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] rd, ma, mw; lsu_err_e er; int lat, rc, wc; mem_op_sz_e sz; bit st; int seen;
        mem_lat = 255;
        bus.i_req_valid = 1'b1; bus.i_req_we = 1'b1; bus.i_req_funct3 = 3'b010;
        bus.i_req_addr = 32'h20; bus.i_req_wdata = 32'h12345678;
        @(posedge clk); @(negedge clk);
        bus.i_req_valid = 1'b0;
        checks++; if (bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== 32'h20) begin failures++; $display("FAIL rm_we_on got=%b/%h exp=1/20", bus.o_mem_we, bus.o_mem_addr); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.o_mem_we !== 1'b0 || bus.o_mem_re !== 1'b0 || bus.o_req_ready !== 1'b0 || bus.o_mem_addr !== 32'd0) begin failures++; $display("FAIL rm_async got=%b%b%b/%h exp=000/0", bus.o_mem_we, bus.o_mem_re, bus.o_req_ready, bus.o_mem_addr); end
        @(negedge clk);
        rst = 1'b0;
        mem_lat = 0;
        #1;
        checks++; if (bus.o_req_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", bus.o_req_ready); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.o_resp_valid || bus.o_mem_we) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rm_no_resp got=%0d exp=0", seen); end
        issue(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, rc, wc, sz, ma, mw, st);
        checks++; if (rd !== ref_load(3'b010, 32'h20) || er !== NONE) begin failures++; $display("FAIL rm_aborted got=%h exp=%h", rd, ref_load(3'b010, 32'h20)); end
    endtask

    task automatic test_random();
        logic [31:0] rd, ma, mw, addr, wd, e_rd; lsu_err_e er, e_er; int lat, rc, wc, r, e_lat, e_wait;
        mem_op_sz_e sz, e_sz; bit st, we, bad; logic [2:0] f3;
        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom_range(0, 300);
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(m_bytes(f3) - 1);
            wd   = $urandom;
            r    = $urandom_range(0, 9);
            mem_lat = (r < 7) ? (r % 3) : ((r == 7) ? 15 : ((r == 8) ? 16 : 30));
            bad  = m_bad(we, f3, addr);
            e_wait = (mem_lat > 15) ? 16 : mem_lat + 1;
            e_lat  = bad ? 1 : 1 + e_wait;
            e_er   = bad ? MISALIGNED : ((mem_lat > 15) ? TIMEOUT : NONE);
            e_rd   = (!we && e_er == NONE) ? ref_load(f3, addr) : 32'd0;
            e_sz   = (m_bytes(f3) == 1) ? BYTE : ((m_bytes(f3) == 2) ? HWORD : WORD);
            issue(we, f3, addr, wd, rd, er, lat, rc, wc, sz, ma, mw, st);
            if (we && e_er == NONE) ref_store(f3, addr, wd);
            checks++; if (er !== e_er || rd !== e_rd) begin failures++; $display("FAIL rnd%0d_resp got=%0d/%h exp=%0d/%h", n, er, rd, e_er, e_rd); end
            checks++; if (lat !== e_lat) begin failures++; $display("FAIL rnd%0d_lat got=%0d exp=%0d", n, lat, e_lat); end
            checks++; if (rc !== ((!we && !bad) ? e_wait : 0) || wc !== ((we && !bad) ? e_wait : 0)) begin failures++; $display("FAIL rnd%0d_strobes got=%0d/%0d", n, rc, wc); end
            if (!bad) begin
                checks++; if (sz !== e_sz || ma !== addr || (we && mw !== wd) || !st) begin failures++; $display("FAIL rnd%0d_membus got=%0d/%h/%h/%0d exp=%0d/%h/%h/1", n, sz, ma, mw, st, e_sz, addr, wd); end
            end
        end
        mem_lat = 0;
    endtask

    initial begin
        for (int i = 0; i < MemBytes; i++) ref_mem[i] = 8'h00;
        bus.i_req_valid  = 1'b0;
        bus.i_req_we     = 1'b0;
        bus.i_req_addr   = 32'd0;
        bus.i_req_wdata  = 32'd0;
        bus.i_req_funct3 = 3'd0;
        bus.i_resp_ready = 1'b1;
        test_reset();
        test_word_and_bytes();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_store();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
